// File: rtl/fpu_addsub_norm_round.sv
// Normalise/round/pack stage behind the single-precision mantissa adder: one shift per cycle, then a round cycle.
// FPU_RNE_ROUND_EN selects round-to-nearest-even; undefined means truncation.
module fpu_addsub_norm_round #(
  parameter int MAN_WIDTH = 24,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [MAN_WIDTH-1:0] in_man,
  input  logic                 in_cout,
  input  logic [2:0]           in_grs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_zero,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t              state, state_nxt;
  logic [24:0]         man25;
  logic signed [9:0]   exp_r;
  logic                sign_r, g_r, r_r, s_r;

  logic                norm_rshift, norm_zero, norm_stop;
  logic                inc;
  logic [24:0]         rsum;
  logic [23:0]         man24;
  logic signed [9:0]   rexp;
  logic [7:0]          pexp;
  logic                ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign norm_rshift = man25[24];
  assign norm_zero   = (man25 == 25'd0) && !g_r && !r_r && !s_r;
  // exp never drops below 1 here, so the left-shift path cannot wrap
  assign norm_stop   = man25[23] || (exp_r <= 10'sd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = NORM;
      NORM: begin
        if (norm_rshift)    state_nxt = NORM;
        else if (norm_zero) state_nxt = DONE;
        else if (norm_stop) state_nxt = ROUND;
        else                state_nxt = NORM;
      end
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FPU_RNE_ROUND_EN
  assign inc = g_r & (r_r | s_r | man25[0]);
`else
  assign inc = 1'b0;
`endif

  always_comb begin
    rsum  = {1'b0, man25[23:0]} + {24'd0, inc};
    man24 = rsum[24] ? 24'h800000 : rsum[23:0];
    rexp  = rsum[24] ? exp_r + 10'sd1 : exp_r;
    pexp  = man24[23] ? rexp[7:0] : 8'h00;
    ovf   = (rexp >= 10'sd255);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man25         <= '0;
      exp_r         <= '0;
      sign_r        <= 1'b0;
      g_r           <= 1'b0;
      r_r           <= 1'b0;
      s_r           <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          man25  <= {in_cout, in_man};
          exp_r  <= (in_exp == '0) ? 10'sd1 : signed'(10'(in_exp));
          sign_r <= in_sign;
          {g_r, r_r, s_r} <= in_grs;
        end
        NORM: begin
          if (norm_rshift) begin
            man25 <= {1'b0, man25[24:1]};
            g_r   <= man25[0];
            r_r   <= g_r;
            s_r   <= r_r | s_r;
            exp_r <= exp_r + 10'sd1;
          end else if (norm_zero) begin
            out_result    <= 32'h0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_zero      <= 1'b1;
          end else if (!norm_stop) begin
            man25 <= {man25[23:0], g_r};
            g_r   <= r_r;
            r_r   <= 1'b0;
            exp_r <= exp_r - 10'sd1;
          end
        end
        ROUND: begin
          out_zero <= 1'b0;
          if (ovf) begin
            out_result    <= {sign_r, 8'hFF, 23'h0};
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
          end else begin
            out_result    <= {sign_r, pexp, man24[22:0]};
            out_overflow  <= 1'b0;
            out_underflow <= (pexp == 8'h00) && (man24 != 24'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
